// File: rtl/alpha_arb_pkg.sv
// Shared types and packet field positions for the alpha memory-port arbiter.
package alpha_arb_pkg;

  // Default packet width; field positions are given relative to this width
  // and re-based onto the actual PKT_W by the users of the package.
  localparam int unsigned PKT_BITS      = 34;
  localparam int unsigned PKT_VALID_BIT = PKT_BITS - 1;
  localparam int unsigned PKT_RESP_BIT  = PKT_BITS - 2;

  typedef enum logic {
    ARB  = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic master_id_t;

endpackage

// File: rtl/alpha_tag_fifo.sv
// Owner-tag FIFO: remembers which master issued each outstanding read so
// responses can be routed back in order.
module alpha_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A push into a full FIFO is only taken when a pop frees a slot that cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alpha_mem_arbiter.sv
// Two-master round-robin arbiter for the core-to-peripheral packet port,
// with in-order response routing through an owner-tag FIFO.
module alpha_mem_arbiter
  import alpha_arb_pkg::*;
#(
  parameter int unsigned PKT_W = PKT_BITS,
  parameter int unsigned OUTST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PKT_W-1:0]         m0_req_pkt_xx,
  output logic                     m0_req_ack_xx,
  output logic [PKT_W-1:0]         m0_resp_pkt_xx,
  input  logic [PKT_W-1:0]         m1_req_pkt_xx,
  output logic                     m1_req_ack_xx,
  output logic [PKT_W-1:0]         m1_resp_pkt_xx,
  output logic [PKT_W-1:0]         mem_req_pkt_xx,
  input  logic                     mem_req_ack_xx,
  input  logic [PKT_W-1:0]         mem_resp_pkt_xx,
  output logic [$clog2(OUTST):0]   outst_cnt,
  output logic                     err_unexp_resp
);

  // Field positions re-based from the package default width onto PKT_W.
  localparam int unsigned V_BIT = PKT_W - PKT_BITS + PKT_VALID_BIT;
  localparam int unsigned R_BIT = PKT_W - PKT_BITS + PKT_RESP_BIT;

  arb_state_t       state_q, state_d;
  master_id_t       grant_q, grant_d;
  master_id_t       rr_q, rr_d;
  logic             err_q, err_d;

  logic             tag_push;
  logic             tag_pop;
  logic [0:0]       tag_din;
  logic [0:0]       tag_head;
  logic             tag_full;
  logic             tag_empty;
  logic             elig0;
  logic             elig1;
  logic             resp_v;
  logic [PKT_W-1:0] sel_pkt;

  // A master may win only if its read would still fit in the tag FIFO.
  assign elig0   = m0_req_pkt_xx[V_BIT] & (~m0_req_pkt_xx[R_BIT] | ~tag_full);
  assign elig1   = m1_req_pkt_xx[V_BIT] & (~m1_req_pkt_xx[R_BIT] | ~tag_full);
  assign sel_pkt = grant_q ? m1_req_pkt_xx : m0_req_pkt_xx;
  assign tag_din = grant_q;

  // Arbitration FSM next-state, request pass-through and accept pulses.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_d           = rr_q;
    mem_req_pkt_xx = '0;
    m0_req_ack_xx  = 1'b0;
    m1_req_ack_xx  = 1'b0;
    tag_push       = 1'b0;
    case (state_q)
      ARB: begin
        if (elig0 && elig1) begin
          grant_d = rr_q;
          rr_d    = ~rr_q;
          state_d = BUSY;
        end else if (elig0) begin
          grant_d = 1'b0;
          state_d = BUSY;
        end else if (elig1) begin
          grant_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_req_pkt_xx = sel_pkt;
        if (grant_q) m1_req_ack_xx = mem_req_ack_xx;
        else         m0_req_ack_xx = mem_req_ack_xx;
        if (mem_req_ack_xx) begin
          state_d  = ARB;
          tag_push = sel_pkt[V_BIT] & sel_pkt[R_BIT];
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Response routing to the owner at the FIFO head; orphans raise the error.
  always_comb begin
    resp_v         = mem_resp_pkt_xx[V_BIT];
    tag_pop        = resp_v & ~tag_empty;
    m0_resp_pkt_xx = '0;
    m1_resp_pkt_xx = '0;
    err_d          = err_q | (resp_v & tag_empty);
    if (tag_pop) begin
      if (tag_head == 1'b0) m0_resp_pkt_xx = mem_resp_pkt_xx;
      else                  m1_resp_pkt_xx = mem_resp_pkt_xx;
    end
  end

  // FSM, grant, round-robin pointer and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign err_unexp_resp = err_q;

  alpha_tag_fifo #(
    .DEPTH (OUTST),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (tag_din),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outst_cnt)
  );

endmodule

// File: tb/tb_alpha_mem_arbiter.sv
// Self-checking bench for alpha_mem_arbiter: directed scenarios plus a
// randomized phase, all compared against a transaction-level model.
module tb_alpha_mem_arbiter;

  localparam int unsigned PKT_W = 16;
  localparam int unsigned OUTST = 4;
  localparam int unsigned CW    = $clog2(OUTST) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [PKT_W-1:0] m0_pkt, m1_pkt, mem_resp;
  logic             mem_ack;
  logic             m0_ack, m1_ack, err;
  logic [PKT_W-1:0] m0_resp, m1_resp, mem_req;
  logic [CW-1:0]    outst_cnt;

  always #5 clk = ~clk;

  alpha_mem_arbiter #(.PKT_W(PKT_W), .OUTST(OUTST)) dut (
    .clk             (clk),
    .reset           (reset),
    .m0_req_pkt_xx   (m0_pkt),
    .m0_req_ack_xx   (m0_ack),
    .m0_resp_pkt_xx  (m0_resp),
    .m1_req_pkt_xx   (m1_pkt),
    .m1_req_ack_xx   (m1_ack),
    .m1_resp_pkt_xx  (m1_resp),
    .mem_req_pkt_xx  (mem_req),
    .mem_req_ack_xx  (mem_ack),
    .mem_resp_pkt_xx (mem_resp),
    .outst_cnt       (outst_cnt),
    .err_unexp_resp  (err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: owner queue, current grant (-1 = arbitrating),
  // favoured master on contention, sticky error.
  int q[$];
  int busy_m;
  int fav;
  bit err_m;
  bit acked [2];

  function automatic logic [PKT_W-1:0] mk_pkt(bit v, bit r);
    logic [PKT_W-3:0] d;
    d = (PKT_W-2)'($urandom);
    return {v, r, d};
  endfunction

  function automatic logic [PKT_W-1:0] mpkt(int i);
    return (i == 0) ? m0_pkt : m1_pkt;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    busy_m = -1;
    fav    = 0;
    err_m  = 1'b0;
  endtask

  // Compare every output with the model's expectation for the current inputs.
  task automatic settle();
    logic [PKT_W-1:0] e_mem, e_r0, e_r1;
    logic e_a0, e_a1;
    #1;
    e_mem = '0; e_r0 = '0; e_r1 = '0; e_a0 = 1'b0; e_a1 = 1'b0;
    if (!reset && busy_m >= 0) begin
      e_mem = mpkt(busy_m);
      if (busy_m == 0) e_a0 = mem_ack; else e_a1 = mem_ack;
    end
    if (!reset && mem_resp[PKT_W-1] && q.size() > 0) begin
      if (q[0] == 0) e_r0 = mem_resp; else e_r1 = mem_resp;
    end
    chk("mem_req", 64'(mem_req), 64'(e_mem));
    chk("m0_ack", 64'(m0_ack), 64'(e_a0));
    chk("m1_ack", 64'(m1_ack), 64'(e_a1));
    chk("m0_resp", 64'(m0_resp), 64'(e_r0));
    chk("m1_resp", 64'(m1_resp), 64'(e_r1));
    chk("outst_cnt", 64'(outst_cnt), 64'(q.size()));
    chk("err", 64'(err), 64'(err_m));
  endtask

  // Advance the model by one clock using the rules, then cross the edge.
  task automatic tick();
    int pre;
    bit el [2];
    logic [PKT_W-1:0] p;
    pre = q.size();
    acked[0] = 1'b0;
    acked[1] = 1'b0;
    if (!reset) begin
      if (mem_resp[PKT_W-1]) begin
        if (pre > 0) void'(q.pop_front());
        else         err_m = 1'b1;
      end
      if (busy_m >= 0) begin
        if (mem_ack) begin
          p = mpkt(busy_m);
          if (p[PKT_W-1] && p[PKT_W-2]) q.push_back(busy_m);
          acked[busy_m] = 1'b1;
          busy_m = -1;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          p = mpkt(i);
          el[i] = p[PKT_W-1] && (!p[PKT_W-2] || pre < int'(OUTST));
        end
        if (el[0] && el[1]) begin busy_m = fav; fav = 1 - fav; end
        else if (el[0]) busy_m = 0;
        else if (el[1]) busy_m = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  // Let any granted request complete, then return every outstanding response.
  task automatic drain();
    mem_ack = 1'b1;
    mem_resp = mk_pkt(1'b0, 1'b0);
    for (int k = 0; k < 4 && busy_m >= 0; k++) cycle();
    m0_pkt = mk_pkt(1'b0, 1'b0);
    m1_pkt = mk_pkt(1'b0, 1'b0);
    mem_ack = 1'b0;
    for (int k = 0; k < 3 * int'(OUTST) + 4 && q.size() > 0; k++) begin
      mem_resp = mk_pkt(1'b1, 1'b0);
      cycle();
    end
    mem_resp = mk_pkt(1'b0, 1'b1);
    cycle();
    chk("drain_empty", 64'(outst_cnt), 64'd0);
  endtask

  initial begin
    logic [PKT_W-1:0] rd, rsp, rsp2;
    int order[$];
    int n;
    bit got0, got1, blk1;
    bit pending [2];

    // Reset state
    reset = 1'b1; m0_pkt = '0; m1_pkt = '0; mem_resp = '0; mem_ack = 1'b0;
    reset_model();
    cycle();
    cycle();
    reset = 1'b0;

    // Single m0 read
    rd = mk_pkt(1'b1, 1'b1);
    m0_pkt = rd; m1_pkt = mk_pkt(1'b0, 1'b1); mem_ack = 1'b1; mem_resp = '0;
    settle(); chk("t1_arb_req_zero", 64'(mem_req), 64'd0); tick();
    settle(); chk("t1_req_pass", 64'(mem_req), 64'(rd)); chk("t1_ack", 64'(m0_ack), 64'd1); tick();
    m0_pkt = mk_pkt(1'b0, 1'b0);
    chk("t1_cnt1", 64'(outst_cnt), 64'd1);
    cycle();
    rsp = mk_pkt(1'b1, 1'b0); mem_resp = rsp;
    settle(); chk("t1_resp_m0", 64'(m0_resp), 64'(rsp)); chk("t1_resp_m1_zero", 64'(m1_resp), 64'd0); tick();
    mem_resp = '0;
    chk("t1_cnt0", 64'(outst_cnt), 64'd0);

    // Both masters streaming reads: alternate grants, 4 done in 8 cycles
    m0_pkt = mk_pkt(1'b1, 1'b1); m1_pkt = mk_pkt(1'b1, 1'b1); mem_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mem_resp = (q.size() > 0) ? mk_pkt(1'b1, 1'b0) : mk_pkt(1'b0, 1'b0);
      cycle();
      if (acked[0]) begin order.push_back(0); m0_pkt = mk_pkt(1'b1, 1'b1); end
      if (acked[1]) begin order.push_back(1); m1_pkt = mk_pkt(1'b1, 1'b1); end
    end
    chk("t2_done_in_8", 64'(order.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("t2_grant_order", 64'((k < order.size()) ? order[k] : 9), 64'(k % 2));
    drain();

    // Tag FIFO full: reads stall, writes still pass
    m0_pkt = mk_pkt(1'b0, 1'b0); m1_pkt = mk_pkt(1'b1, 1'b1); mem_ack = 1'b1;
    mem_resp = mk_pkt(1'b0, 1'b1); n = 0;
    for (int k = 0; k < 6 * int'(OUTST) && n < int'(OUTST); k++) begin
      cycle();
      if (acked[1]) begin n++; m1_pkt = mk_pkt(1'b1, 1'b1); end
    end
    chk("t3_fill_acks", 64'(n), 64'(OUTST));
    chk("t3_cnt_full", 64'(outst_cnt), 64'(OUTST));
    m0_pkt = mk_pkt(1'b1, 1'b0); got0 = 1'b0; blk1 = 1'b0;
    for (int k = 0; k < 4 && !got0; k++) begin
      cycle();
      if (acked[0]) got0 = 1'b1;
      if (acked[1]) blk1 = 1'b1;
    end
    chk("t3_write_granted", 64'(got0), 64'd1);
    m0_pkt = mk_pkt(1'b0, 1'b0);
    settle(); chk("t3_blocked_valid", 64'(mem_req[PKT_W-1]), 64'd0); chk("t3_blocked_ack", 64'(m1_ack), 64'd0); tick();
    if (acked[1]) blk1 = 1'b1;
    chk("t3_read_held", 64'(blk1), 64'd0);
    chk("t3_cnt_still_full", 64'(outst_cnt), 64'(OUTST));
    mem_resp = mk_pkt(1'b1, 1'b0);
    cycle();
    mem_resp = mk_pkt(1'b0, 1'b0); got1 = 1'b0;
    for (int k = 0; k < 2 && !got1; k++) begin
      cycle();
      if (acked[1]) got1 = 1'b1;
    end
    chk("t3_read_after_release", 64'(got1), 64'd1);
    m1_pkt = mk_pkt(1'b0, 1'b1);
    drain();

    // Push and pop in the same cycle
    m1_pkt = mk_pkt(1'b1, 1'b1); mem_ack = 1'b1; mem_resp = '0;
    for (int k = 0; k < 4 && !acked[1]; k++) cycle();
    m1_pkt = mk_pkt(1'b0, 1'b0);
    chk("t4_cnt1", 64'(outst_cnt), 64'd1);
    m0_pkt = mk_pkt(1'b1, 1'b1);
    cycle();
    rsp = mk_pkt(1'b1, 1'b0); mem_resp = rsp;
    settle(); chk("t4_resp_m1", 64'(m1_resp), 64'(rsp)); chk("t4_ack_m0", 64'(m0_ack), 64'd1); tick();
    m0_pkt = mk_pkt(1'b0, 1'b0);
    chk("t4_cnt_same", 64'(outst_cnt), 64'd1);
    rsp2 = mk_pkt(1'b1, 1'b1); mem_resp = rsp2;
    settle(); chk("t4_head_m0", 64'(m0_resp), 64'(rsp2)); chk("t4_m1_zero", 64'(m1_resp), 64'd0); tick();
    mem_resp = '0;
    chk("t4_cnt0", 64'(outst_cnt), 64'd0);

    // Randomized traffic against the model
    pending[0] = 1'b0; pending[1] = 1'b0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          if (i == 0) m0_pkt = mk_pkt(1'b1, 1'($urandom_range(0, 1)));
          else        m1_pkt = mk_pkt(1'b1, 1'($urandom_range(0, 1)));
        end else if (!pending[i]) begin
          if (i == 0) m0_pkt = mk_pkt(1'b0, 1'($urandom_range(0, 1)));
          else        m1_pkt = mk_pkt(1'b0, 1'($urandom_range(0, 1)));
        end
      end
      mem_ack = 1'($urandom_range(0, 1));
      mem_resp = (q.size() > 0 && $urandom_range(0, 9) < 4) ? mk_pkt(1'b1, 1'($urandom_range(0, 1)))
                                                           : mk_pkt(1'b0, 1'($urandom_range(0, 1)));
      cycle();
      for (int i = 0; i < 2; i++) if (acked[i]) pending[i] = 1'b0;
    end
    drain();

    // Unexpected response with empty tag FIFO
    mem_resp = mk_pkt(1'b1, 1'b0);
    settle(); chk("t5_r0_zero", 64'(m0_resp), 64'd0); chk("t5_r1_zero", 64'(m1_resp), 64'd0); tick();
    mem_resp = '0;
    settle(); chk("t5_err_set", 64'(err), 64'd1); tick();
    cycle(); cycle();
    settle(); chk("t5_err_sticky", 64'(err), 64'd1); tick();

    // Asynchronous reset while BUSY with two outstanding reads
    m0_pkt = mk_pkt(1'b1, 1'b1); m1_pkt = mk_pkt(1'b1, 1'b1); mem_ack = 1'b1;
    for (int k = 0; k < 12 && q.size() < 2; k++) begin
      cycle();
      if (acked[0]) m0_pkt = mk_pkt(1'b0, 1'b0);
      if (acked[1]) m1_pkt = mk_pkt(1'b0, 1'b0);
    end
    m1_pkt = mk_pkt(1'b0, 1'b0);
    rd = mk_pkt(1'b1, 1'b1); m0_pkt = rd; mem_ack = 1'b0;
    for (int k = 0; k < 4 && busy_m < 0; k++) cycle();
    chk("t6_pre_cnt2", 64'(outst_cnt), 64'd2);
    chk("t6_pre_busy", 64'(mem_req), 64'(rd));
    mem_resp = mk_pkt(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t6_rst_m0_ack", 64'(m0_ack), 64'd0);
    chk("t6_rst_m1_ack", 64'(m1_ack), 64'd0);
    chk("t6_rst_m0_resp", 64'(m0_resp), 64'd0);
    chk("t6_rst_m1_resp", 64'(m1_resp), 64'd0);
    chk("t6_rst_cnt", 64'(outst_cnt), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    reset_model();
    #2;
    reset = 1'b0;
    settle(); chk("t6_stray_dropped", 64'(m0_resp), 64'd0); chk("t6_arb_cycle", 64'(mem_req), 64'd0); tick();
    mem_resp = '0; mem_ack = 1'b1;
    settle(); chk("t6_post_grant", 64'(mem_req), 64'(rd)); chk("t6_post_ack", 64'(m0_ack), 64'd1); tick();
    m0_pkt = mk_pkt(1'b0, 1'b0);
    chk("t6_stray_err", 64'(err), 64'd1);
    chk("t6_post_cnt", 64'(outst_cnt), 64'd1);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
